// File: rtl/sreg_out_if.sv
// sreg_out_if: groups the parallel-load handshake, the MCU serial pins and the
// status outputs of sreg_out into one bundle.
//   master : the side that supplies data/load and plays the MCU (drives sclk, cs_n)
//   slave  : the shift register itself (drives ready, sout, done, abort, underrun, debug)
// Signals:
//   data[DWIDTH-1:0]  parallel word to transmit
//   load              one-cycle capture strobe, honoured only while ready=1
//   ready             block can accept load
//   sclk, cs_n        asynchronous serial clock / active-low select from the MCU
//   sout              serial data to the MCU, MSB first
//   done, abort       one-cycle completion / early-termination pulses
//   underrun          sticky: MCU clocked while nothing was loaded
//   debug[7:0]        {state[1:0], bit_cnt[5:0]}
interface sreg_out_if #(
    parameter int unsigned DWIDTH = 8
);
    logic [DWIDTH-1:0] data;
    logic              load;
    logic              ready;
    logic              sclk;
    logic              cs_n;
    logic              sout;
    logic              done;
    logic              abort;
    logic              underrun;
    logic [7:0]        debug;

    modport master (
        output data, load, sclk, cs_n,
        input  ready, sout, done, abort, underrun, debug
    );

    modport slave (
        input  data, load, sclk, cs_n,
        output ready, sout, done, abort, underrun, debug
    );
endinterface

// File: rtl/sreg_out.sv
// sreg_out: parallel-in / serial-out shift register read by an external MCU.
// A word is loaded through the data/load/ready handshake, then shifted out MSB
// first on the MCU's sclk while cs_n is low. sclk and cs_n are asynchronous to clk
// and are synchronized before use, which limits sclk to clk/(2*(SYNC_STAGES+2)).
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous active-high reset
//   bus    sreg_out_if slave modport (data, load, ready, sclk, cs_n, sout,
//          done, abort, underrun, debug)
// Parameters:
//   DWIDTH       word width and bits per transfer (>= 2, <= 63 for full debug view)
//   SYNC_STAGES  synchronizer depth for sclk and cs_n, 2..3
module sreg_out #(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic       clk,
    input logic       reset,
    sreg_out_if.slave bus
);

    // Wide enough to hold DWIDTH itself so the count never wraps mid-transfer.
    localparam int unsigned CW = $clog2(DWIDTH + 1);
    localparam logic [CW-1:0] LastCnt = CW'(DWIDTH - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLoaded = 2'd1,
        StShift  = 2'd2,
        StFin    = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s;
    logic cs_s;
    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // ------------------------------------------------------------------
    // Datapath and FSM state
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [DWIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              underrun_q, underrun_d;
    logic              abort_q, abort_d;

    logic last_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            underrun_q <= underrun_d;
            abort_q    <= abort_d;
        end
    end

    // The edge that shifts out the final bit; it takes priority over a
    // simultaneous cs_n rise so a completed word is never reported as aborted.
    assign last_shift = sclk_rise && (bit_cnt_q == LastCnt);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        underrun_d = underrun_q;
        abort_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sclk_rise && !cs_s) begin
                    underrun_d = 1'b1;
                end
                // An accepted load clears underrun even if the MCU clocked
                // in the same cycle.
                if (bus.load) begin
                    shreg_d    = bus.data;
                    bit_cnt_d  = '0;
                    underrun_d = 1'b0;
                    state_d    = StLoaded;
                end
            end

            StLoaded: begin
                // cs_n already low on entry counts the same as a fresh falling
                // edge; a cs_n rise here is harmless and keeps the word.
                if (cs_fall || !cs_s) begin
                    state_d = StShift;
                end
            end

            StShift: begin
                if (sclk_rise) begin
                    shreg_d   = {shreg_q[DWIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (last_shift) begin
                        state_d = StFin;
                    end
                end
                if (cs_rise && !last_shift) begin
                    abort_d   = 1'b1;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = StIdle;
                end
            end

            StFin: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // sout follows the registered shreg MSB, so it changes the cycle after an
    // sclk edge is detected and holds for the whole following low phase.
    assign bus.ready    = (state_q == StIdle);
    assign bus.sout     = ((state_q == StLoaded) || (state_q == StShift)) ?
                          shreg_q[DWIDTH-1] : 1'b0;
    assign bus.done     = (state_q == StFin);
    assign bus.abort    = abort_q;
    assign bus.underrun = underrun_q;
    assign bus.debug    = {state_q, 6'(bit_cnt_q)};

endmodule

// File: doc/sreg_out.md
SREG_OUT -- requirements
Module: sreg_out

Interface
REQ-001 Parameter DWIDTH, default 8: parallel word width and number of bits shifted per transfer.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk and cs_n; legal values 2..3.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 data  input  DWIDTH  parallel word to transmit.
REQ-006 load  input  1  one-cycle strobe; captures data when ready=1.
REQ-007 ready  output  1  high when the block can accept load.
REQ-008 sclk  input  1  serial clock from the MCU, asynchronous to clk.
REQ-009 cs_n  input  1  active-low transfer select from the MCU, asynchronous to clk.
REQ-010 sout  output  1  serial data to the MCU, MSB first.
REQ-011 done  output  1  one-cycle pulse when all DWIDTH bits have been shifted.
REQ-012 abort  output  1  one-cycle pulse when cs_n rises before the transfer completes.
REQ-013 underrun  output  1  sticky flag: the MCU clocked while no word was loaded.
REQ-014 debug  output  8  {state[1:0], bit_cnt[5:0]}.

Function
REQ-015 sclk and cs_n shall each pass through SYNC_STAGES flip-flops; edges shall be detected on the synchronized values against one extra registered copy.
REQ-016 The FSM shall have four states, encoded IDLE=0, LOADED=1, SHIFT=2, FIN=3.
REQ-017 IDLE: ready=1 and sout=0; load=1 shall capture data into shreg, clear bit_cnt, clear underrun, and move to LOADED on the next clock.
REQ-018 load while ready=0 shall be ignored without altering shreg.
REQ-019 LOADED: ready=0; sout shall equal shreg[DWIDTH-1] from the first cycle in LOADED onward.
REQ-020 LOADED: a detected synchronized cs_n falling edge, or cs_n synchronized low on entry, shall move the FSM to SHIFT.
REQ-021 SHIFT: each detected synchronized sclk rising edge shall shift shreg left by one, fill with 0, and increment bit_cnt.
REQ-022 SHIFT: sout shall update in the clk cycle after the edge is detected, giving the MCU a full sclk low phase of setup before its next rising edge.
REQ-023 SHIFT: when bit_cnt reaches DWIDTH, the FSM shall move to FIN.
REQ-024 FIN: done=1 for exactly one cycle, then the FSM returns to IDLE and sout=0.
REQ-025 A detected synchronized cs_n rising edge in SHIFT with bit_cnt<DWIDTH shall pulse abort for one cycle, discard the word, and return the FSM to IDLE.
REQ-026 A cs_n rising edge in LOADED shall not abort; the word stays loaded.
REQ-027 A synchronized sclk rising edge in IDLE while synchronized cs_n=0 shall set underrun; underrun clears only on reset or an accepted load.
REQ-028 If the last sclk edge and a cs_n rise are detected in the same cycle, completion wins: done pulses and abort does not.
REQ-029 bit_cnt shall be at least clog2(DWIDTH+1) bits wide and shall never wrap within a transfer.
REQ-030 sclk edges in LOADED or FIN shall be ignored.
REQ-031 The maximum supported sclk frequency shall be clk/(2*(SYNC_STAGES+2)).

Reset
REQ-032 reset shall force: FSM=IDLE, shreg=0, bit_cnt=0, ready=1, sout=0, done=0, abort=0, underrun=0, and all synchronizer flops to idle values (sclk=0, cs_n=1).
REQ-033 reset asserted mid-transfer shall abandon the word with no done or abort pulse.
REQ-034 reset and load in the same cycle: reset wins, the word is not captured.

Verification
REQ-035 Basic transfer: load data=8'hA5, then cs_n low, then 8 sclk pulses at clk/16 -> sout bits sampled on sclk rises read 1,0,1,0,0,1,0,1; done pulses once; ready returns to 1.
REQ-036 Abort: load 8'hFF, cs_n low, 3 sclk pulses, cs_n high -> abort pulses once, done never asserts, ready=1, sout=0.
REQ-037 Underrun and clear: cs_n low with 2 sclk pulses in IDLE -> underrun=1; a later load 8'h3C clears underrun; a full transfer then returns 0,0,1,1,1,1,0,0.
REQ-038 Ignored load: a second load of 8'h00 during a transfer of 8'h81 -> transmitted bits remain 1,0,0,0,0,0,0,1.
REQ-039 Reset mid-transfer: reset after 4 of 8 sclk pulses -> next cycle ready=1, sout=0, no done or abort pulse; a following transfer of 8'h5A is correct.
REQ-040 Width parameter: with DWIDTH=21, transfer 21'h1ABCDE -> 21 bits MSB first match; done follows the 21st sclk rise.
